fpga_ram_ctrl: RTL and testbench
================================

# fpga_ram_ctrl

Request/response front end for the single-port FPGA RAM (1-cycle registered read, write-first, output register reloaded on every clock). It sits directly upstream of the RAM, drives its address, write-data and write-enable pins, and consumes its read data. It clears the whole array after reset and converts the RAM's fixed-latency read data into a valid/ready response stream with a 2-entry buffer, so backpressure never loses data.

## Interface
- DATAWIDTH, 32, data bits; matches the RAM's DATAWIDTH
- ADDRWIDTH, 10, address bits; MEMDEPTH = 2**ADDRWIDTH
- CLEAR_ON_RESET, 1, 1 = write INIT_VALUE to every location after reset
- INIT_VALUE, '0, DATAWIDTH-bit fill value
- PortAClk  in  1  single clock, rising edge; the RAM uses the same clock
- PortARst_b  in  1  **synchronous, active-low reset**
- ReqValid  in  1  request valid
- ReqReady  out  1  request accepted when ReqValid && ReqReady
- ReqWrite  in  1  1 = write, 0 = read
- ReqAddr  in  ADDRWIDTH  request address
- ReqData  in  DATAWIDTH  write data; ignored for reads
- RspValid  out  1  read response valid
- RspReady  in  1  response consumed when RspValid && RspReady
- RspData  out  DATAWIDTH  read data
- InitBusy  out  1  clear sweep in progress
- RamAddr  out  ADDRWIDTH  connects to the RAM's PortAAddr
- RamDataIn  out  DATAWIDTH  connects to the RAM's PortADataIn
- RamWriteEnable  out  1  connects to the RAM's PortAWriteEnable
- RamDataOut  in  DATAWIDTH  connects to the RAM's PortADataOut

## Operation
- **States:** INIT and RUN. Reset forces INIT, sets the sweep counter to 0, empties the buffer and clears `inflight`.
- **INIT with CLEAR_ON_RESET=1:**
  - Each cycle: RamWriteEnable=1, RamAddr=counter, RamDataIn=INIT_VALUE, then counter increments.
  - After the write to MEMDEPTH-1, the next state is RUN. INIT lasts exactly MEMDEPTH cycles.
  - Counter is ADDRWIDTH+1 bits, so there is no wrap ambiguity.
- **INIT with CLEAR_ON_RESET=0:** one cycle with no RAM write, then RUN.
- **InitBusy:** equals (state==INIT). ReqReady=0 throughout INIT.
- **RUN, request acceptance:** ReqReady = (occ + inflight) < 2, where occ is the buffer occupancy (0..2). ReqReady does not depend on ReqValid or ReqWrite.
- **RUN, on accept:**
  - RamAddr=ReqAddr.
  - RamWriteEnable=ReqWrite.
  - RamDataIn=ReqData.
  - Reads set `inflight` for the next cycle.
  - Writes are posted and produce no response.
- **RUN, no accept:** RamWriteEnable=0, and RamAddr holds its last value. The RAM output register is therefore overwritten every cycle, which is why read data is only valid in the cycle after issue.
- **Response path:**
  - RspValid = inflight || occ>0.
  - RspData = buffer head if occ>0, else RamDataOut (bypass).
  - If inflight, occ==0 and RspReady=1: the data passes straight through and is not stored.
  - If inflight and the data is not consumed this cycle: RamDataOut is pushed into the buffer.
  - Responses stay in request order.
- **Simultaneous events:**
  - Push and pop in the same cycle keeps occ unchanged.
  - Buffer overflow is impossible by construction, given the ReqReady rule.
- **Back-to-back access:** a read followed by a write to the same address returns the old data.
- **Reset mid-operation:** the buffer and inflight read are dropped, outputs take reset values, and the INIT sweep restarts from address 0.
- **RAM writes during reset:** RamWriteEnable is forced to 0 while PortARst_b=0.

## Timing
- Reset values: ReqReady=0, RspValid=0, RspData=don't-care, InitBusy=1, RamWriteEnable=0, RamAddr=0, RamDataIn=INIT_VALUE.
- First request can be accepted MEMDEPTH+1 cycles after reset deasserts (CLEAR_ON_RESET=1), or 2 cycles after (CLEAR_ON_RESET=0).
- Read accepted in cycle T gives RspValid=1 in T+1. This is the minimum latency.
- With RspReady held high, throughput is one read per cycle.
- With RspReady low: at most 2 reads are outstanding. ReqReady drops while occ+inflight==2 and rises the cycle after a pop.
- Writes: the RAM is updated at the end of the accept cycle.

## Structure
- Package fpga_ram_ctrl_pkg holds:
  - the state enum (INIT, RUN)
  - the constant RSP_DEPTH=2
- Sub-module fpga_ram_rsp_buf: 2-entry synchronous FIFO with push, pop, occ, head and a synchronous active-low clear.
- Top level holds the FSM, sweep counter, inflight flag, bypass mux and ReqReady logic.

## Test plan
- **Reset sweep:** ADDRWIDTH=4, INIT_VALUE=32'hA5A5A5A5 → 16 consecutive writes to addresses 0..15, InitBusy high for 16 cycles, ReqReady first high in cycle 17; reading any address returns A5A5A5A5.
- **Streaming reads:** write 0x100+i to addresses 0..7, then 8 back-to-back reads with RspReady=1 → RspData 0x100..0x107 on consecutive cycles, each one cycle after its accept.
- **Backpressure:** RspReady=0, issue reads of addresses 1, 2, 3 → only 2 accepted, ReqReady=0 thereafter; raise RspReady → data 0x101, 0x102 in order, then the third read is accepted.
- **Read-then-write, same address:** address 5 holds 0x55; read 5 then write 5 = 0x77 back-to-back → response 0x55; a later read returns 0x77.
- **Reset mid-operation:** with 2 responses buffered, assert PortARst_b for 1 cycle → RspValid=0 the next cycle, InitBusy=1, and the sweep restarts at address 0 with no stale response delivered.
- **CLEAR_ON_RESET=0:** ReqReady=1 two cycles after reset release, and no RAM writes occur during INIT.

Source files
------------

// File: rtl/fpga_ram_ctrl_pkg.sv
// Shared types and constants for the FPGA RAM request/response front end.
package fpga_ram_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

    // Response buffer depth; two entries cover the one-cycle RAM read latency.
    localparam int RSP_DEPTH = 2;

    // Width able to hold 0..RSP_DEPTH+1 (buffer occupancy plus one inflight read).
    localparam int OCC_W = $clog2(RSP_DEPTH + 2);

endpackage

// File: rtl/fpga_ram_rsp_buf.sv
// Small synchronous FIFO holding read data that the consumer has not yet taken.
module fpga_ram_rsp_buf
    import fpga_ram_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 clr_b_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [DATAWIDTH-1:0] data_i,
    output logic [DATAWIDTH-1:0] head_o,
    output logic [OCC_W-1:0]     occ_o
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [DATAWIDTH-1:0] entries_q [RSP_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy next-state; push and pop together leave occupancy unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_i) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (push_i && !pop_i) begin
            occ_d = occ_q + 1'b1;
        end else if (pop_i && !push_i) begin
            occ_d = occ_q - 1'b1;
        end
    end

    // Storage and pointer registers; clear empties the FIFO but leaves data untouched.
    always_ff @(posedge clk_i) begin
        if (!clr_b_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (push_i) begin
                entries_q[wr_ptr_q] <= data_i;
            end
        end
    end

    assign head_o = entries_q[rd_ptr_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/fpga_ram_ctrl.sv
// Front end for a single-port registered-read RAM: clears the array after reset,
// then turns requests into RAM pin activity and read data into a valid/ready stream.
//
//   state   | meaning
//   ST_INIT | post-reset sweep (or single idle cycle when clearing is disabled)
//   ST_RUN  | accepting requests and delivering read responses
module fpga_ram_ctrl
    import fpga_ram_ctrl_pkg::*;
#(
    parameter int                   DATAWIDTH      = 32,
    parameter int                   ADDRWIDTH      = 10,
    parameter bit                   CLEAR_ON_RESET = 1'b1,
    parameter logic [DATAWIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic                 PortAClk,
    input  logic                 PortARst_b,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic                 ReqWrite,
    input  logic [ADDRWIDTH-1:0] ReqAddr,
    input  logic [DATAWIDTH-1:0] ReqData,
    output logic                 RspValid,
    input  logic                 RspReady,
    output logic [DATAWIDTH-1:0] RspData,
    output logic                 InitBusy,
    output logic [ADDRWIDTH-1:0] RamAddr,
    output logic [DATAWIDTH-1:0] RamDataIn,
    output logic                 RamWriteEnable,
    input  logic [DATAWIDTH-1:0] RamDataOut
);

    localparam int                 MEMDEPTH  = 2 ** ADDRWIDTH;
    localparam logic [ADDRWIDTH:0] LAST_ADDR = (ADDRWIDTH + 1)'(MEMDEPTH - 1);

    ctrl_state_e            state_q, state_d;
    logic [ADDRWIDTH:0]     cnt_q, cnt_d;
    logic                   inflight_q, inflight_d;
    logic [ADDRWIDTH-1:0]   addr_q, addr_d;

    logic [OCC_W-1:0]       buf_occ;
    logic [OCC_W-1:0]       outstanding;
    logic [DATAWIDTH-1:0]   buf_head;
    logic                   buf_push;
    logic                   buf_pop;
    logic                   buf_empty;

    // Reads accepted but not yet consumed: buffered entries plus the one in the RAM pipe.
    assign outstanding = buf_occ + OCC_W'(inflight_q);
    assign buf_empty   = (buf_occ == '0);

    // Next-state and RAM pin drive; RamAddr holds when idle so the pins stay quiet.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        inflight_d     = 1'b0;
        ReqReady       = 1'b0;
        RamWriteEnable = 1'b0;
        RamAddr        = addr_q;
        RamDataIn      = INIT_VALUE;

        case (state_q)
            ST_INIT: begin
                RamAddr = cnt_q[ADDRWIDTH-1:0];
                if (CLEAR_ON_RESET) begin
                    RamWriteEnable = 1'b1;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ReqReady = (outstanding < OCC_W'(RSP_DEPTH));
                if (ReqValid && ReqReady) begin
                    RamAddr        = ReqAddr;
                    RamWriteEnable = ReqWrite;
                    RamDataIn      = ReqData;
                    inflight_d     = !ReqWrite;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Keep the RAM untouched and the handshakes idle while reset is held.
        if (!PortARst_b) begin
            ReqReady       = 1'b0;
            RamWriteEnable = 1'b0;
            RamAddr        = '0;
            RamDataIn      = INIT_VALUE;
        end

        addr_d = RamAddr;
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge PortAClk) begin
        if (!PortARst_b) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            addr_q     <= addr_d;
        end
    end

    // Fresh RAM data bypasses the buffer only when nothing older is waiting and it is taken now.
    assign buf_pop   = !buf_empty && RspReady;
    assign buf_push  = inflight_q && !(buf_empty && RspReady);

    assign RspValid  = PortARst_b && (inflight_q || !buf_empty);
    assign RspData   = buf_empty ? RamDataOut : buf_head;
    assign InitBusy  = (state_q == ST_INIT);

    fpga_ram_rsp_buf #(
        .DATAWIDTH (DATAWIDTH)
    ) u_rsp_buf (
        .clk_i   (PortAClk),
        .clr_b_i (PortARst_b),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .data_i  (RamDataOut),
        .head_o  (buf_head),
        .occ_o   (buf_occ)
    );

endmodule

// File: tb/tb_fpga_ram_ctrl.sv
// Bench for fpga_ram_ctrl: a behavioural RAM, a shadow-memory/response-queue model,
// and one task per scenario.
module tb_fpga_ram_ctrl;

    localparam int          DW    = 32;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] FILL  = 32'hA5A5A5A5;

    logic          clk, rst_b, rst2_b;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          init_busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;

    logic          nc_req_valid, nc_req_ready, nc_req_write, nc_rsp_valid, nc_rsp_ready;
    logic          nc_busy, nc_we;
    logic [AW-1:0] nc_req_addr, nc_ram_addr;
    logic [DW-1:0] nc_req_data, nc_rsp_data, nc_ram_din, nc_ram_dout;

    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic          model_run;

    logic          s_acc, s_rsp, s_rdy, s_vld, s_busy, s_we;
    logic          s_exp_rdy, s_exp_vld, s_exp_ok;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data, s_din, s_exp;

    int total = 0;
    int bad   = 0;

    fpga_ram_ctrl #(
        .DATAWIDTH(DW), .ADDRWIDTH(AW), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(FILL)
    ) u_dut (
        .PortAClk(clk), .PortARst_b(rst_b),
        .ReqValid(req_valid), .ReqReady(req_ready), .ReqWrite(req_write),
        .ReqAddr(req_addr), .ReqData(req_data),
        .RspValid(rsp_valid), .RspReady(rsp_ready), .RspData(rsp_data),
        .InitBusy(init_busy), .RamAddr(ram_addr), .RamDataIn(ram_din),
        .RamWriteEnable(ram_we), .RamDataOut(ram_dout)
    );

    fpga_ram_ctrl #(
        .DATAWIDTH(DW), .ADDRWIDTH(AW), .CLEAR_ON_RESET(1'b0), .INIT_VALUE(FILL)
    ) u_nc (
        .PortAClk(clk), .PortARst_b(rst2_b),
        .ReqValid(nc_req_valid), .ReqReady(nc_req_ready), .ReqWrite(nc_req_write),
        .ReqAddr(nc_req_addr), .ReqData(nc_req_data),
        .RspValid(nc_rsp_valid), .RspReady(nc_rsp_ready), .RspData(nc_rsp_data),
        .InitBusy(nc_busy), .RamAddr(nc_ram_addr), .RamDataIn(nc_ram_din),
        .RamWriteEnable(nc_we), .RamDataOut(nc_ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port RAM: registered read, write-first, output reloaded every clock.
    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_addr] <= ram_din;
            ram_dout          <= ram_din;
        end else begin
            ram_dout <= ram_mem[ram_addr];
        end
    end

    // One clock: sample at the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        s_rdy     = req_ready;
        s_vld     = rsp_valid;
        s_busy    = init_busy;
        s_we      = ram_we;
        s_addr    = ram_addr;
        s_din     = ram_din;
        s_data    = rsp_data;
        s_exp_rdy = model_run && rst_b && (exp_q.size() < 2);
        s_exp_vld = rst_b && (exp_q.size() > 0);
        s_acc     = req_valid && req_ready;
        s_rsp     = rsp_valid && rsp_ready;
        s_exp_ok  = 1'b0;
        s_exp     = 'x;
        if (s_rsp && exp_q.size() > 0) begin
            s_exp    = exp_q.pop_front();
            s_exp_ok = 1'b1;
        end
        if (s_acc) begin
            if (req_write) ref_mem[req_addr] = req_data;
            else           exp_q.push_back(ref_mem[req_addr]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tick();
        total++; if (s_rdy !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", s_rdy); end
        total++; if (s_vld !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", s_vld); end
        total++; if (s_busy !== 1'b1) begin bad++; $display("FAIL reset_init_busy got=%b exp=1", s_busy); end
        total++; if (s_we !== 1'b0) begin bad++; $display("FAIL reset_ram_we got=%b exp=0", s_we); end
        total++; if (s_addr !== '0) begin bad++; $display("FAIL reset_ram_addr got=%h exp=0", s_addr); end
        total++; if (s_din !== FILL) begin bad++; $display("FAIL reset_ram_din got=%h exp=%h", s_din, FILL); end
    endtask

    task automatic test_sweep();
        rst_b = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            total++;
            if (s_busy !== 1'b1 || s_we !== 1'b1 || s_addr !== AW'(i) || s_din !== FILL || s_rdy !== 1'b0) begin
                bad++;
                $display("FAIL sweep_cycle%0d got busy=%b we=%b addr=%h din=%h rdy=%b exp 1 1 %h %h 0",
                         i, s_busy, s_we, s_addr, s_din, s_rdy, AW'(i), FILL);
            end
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = FILL;
        model_run = 1'b1;
        tick();
        total++; if (s_rdy !== 1'b1 || s_busy !== 1'b0) begin bad++; $display("FAIL sweep_done got rdy=%b busy=%b exp 1 0", s_rdy, s_busy); end
        rsp_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            req_valid = (k < 5);
            req_write = 1'b0;
            req_addr  = AW'($urandom_range(0, DEPTH - 1));
            tick();
            total++; if (s_rdy !== s_exp_rdy) begin bad++; $display("FAIL clear_rd_ready got=%b exp=%b", s_rdy, s_exp_rdy); end
            if (s_rsp) begin
                total++; if (!s_exp_ok || s_data !== FILL) begin bad++; $display("FAIL clear_rd_data got=%h exp=%h", s_data, FILL); end
            end
        end
    endtask

    task automatic test_streaming();
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(i); req_data = 32'h100 + i;
            tick();
            total++; if (s_acc !== 1'b1) begin bad++; $display("FAIL stream_wr_accept%0d got=%b exp=1", i, s_acc); end
        end
        for (int k = 0; k < 9; k++) begin
            req_valid = (k < 8); req_write = 1'b0; req_addr = AW'(k);
            tick();
            if (k < 8) begin
                total++; if (s_acc !== 1'b1) begin bad++; $display("FAIL stream_rd_accept%0d got=%b exp=1", k, s_acc); end
            end
            if (k > 0) begin
                total++;
                if (s_vld !== 1'b1 || s_data !== 32'h100 + k - 1) begin
                    bad++;
                    $display("FAIL stream_rd_data%0d got valid=%b data=%h exp 1 %h", k - 1, s_vld, s_data, 32'h100 + k - 1);
                end
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] got [$];
        int ai;
        ai = 1;
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(ai);
            tick();
            total++; if (s_rdy !== s_exp_rdy) begin bad++; $display("FAIL bp_stall_ready%0d got=%b exp=%b", k, s_rdy, s_exp_rdy); end
            if (s_acc) ai++;
        end
        total++; if (ai !== 3) begin bad++; $display("FAIL bp_accepted got=%0d exp=2", ai - 1); end
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_valid = (ai <= 3); req_addr = AW'(ai);
            tick();
            total++; if (s_rdy !== s_exp_rdy) begin bad++; $display("FAIL bp_drain_ready%0d got=%b exp=%b", k, s_rdy, s_exp_rdy); end
            if (s_rsp) begin
                got.push_back(s_data);
                total++; if (!s_exp_ok || s_data !== s_exp) begin bad++; $display("FAIL bp_drain_data got=%h exp=%h", s_data, s_exp); end
            end
            if (s_acc) ai++;
        end
        total++;
        if (got.size() != 3 || got[0] !== 32'h101 || got[1] !== 32'h102 || got[2] !== 32'h103) begin
            bad++;
            $display("FAIL bp_order got n=%0d exp 101,102,103", got.size());
        end
        req_valid = 1'b0;
    endtask

    task automatic test_rd_then_wr();
        logic [DW-1:0] got [$];
        logic          v_wr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [DW-1:0] v_dt [4] = '{32'h55, 32'h0, 32'h77, 32'h0};
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_valid = (k < 4); req_addr = AW'(5);
            if (k < 4) begin req_write = v_wr[k]; req_data = v_dt[k]; end
            tick();
            if (s_rsp) begin
                got.push_back(s_data);
                total++; if (!s_exp_ok || s_data !== s_exp) begin bad++; $display("FAIL rw_data got=%h exp=%h", s_data, s_exp); end
            end
        end
        total++;
        if (got.size() != 2 || got[0] !== 32'h55 || got[1] !== 32'h77) begin
            bad++;
            $display("FAIL rw_same_addr got n=%0d exp 55 then 77", got.size());
        end
        req_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_write = ($urandom_range(0, 2) == 0);
            req_addr  = AW'($urandom_range(0, DEPTH - 1));
            req_data  = $urandom();
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
            total++; if (s_rdy !== s_exp_rdy) begin bad++; $display("FAIL rand_ready cyc%0d got=%b exp=%b", k, s_rdy, s_exp_rdy); end
            total++; if (s_vld !== s_exp_vld) begin bad++; $display("FAIL rand_valid cyc%0d got=%b exp=%b", k, s_vld, s_exp_vld); end
            if (s_rsp) begin
                total++; if (!s_exp_ok || s_data !== s_exp) begin bad++; $display("FAIL rand_data cyc%0d got=%h exp=%h", k, s_data, s_exp); end
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        for (int k = 0; k < 6 && exp_q.size() < 2; k++) begin
            req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(k);
            tick();
        end
        req_valid = 1'b0;
        tick();
        total++; if (s_vld !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b exp=1", s_vld); end
        rst_b = 1'b0;
        exp_q.delete();
        model_run = 1'b0;
        rsp_ready = 1'b1;
        tick();
        total++; if (s_we !== 1'b0 || s_vld !== 1'b0) begin bad++; $display("FAIL mid_in_reset got we=%b valid=%b exp 0 0", s_we, s_vld); end
        rst_b = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            total++;
            if (s_vld !== 1'b0 || s_busy !== 1'b1 || s_we !== 1'b1 || s_addr !== AW'(i)) begin
                bad++;
                $display("FAIL mid_sweep%0d got valid=%b busy=%b we=%b addr=%h exp 0 1 1 %h", i, s_vld, s_busy, s_we, s_addr, AW'(i));
            end
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = FILL;
        model_run = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_valid = (k < 4); req_write = 1'b0; req_addr = AW'(k + 1);
            tick();
            total++; if (s_vld !== s_exp_vld) begin bad++; $display("FAIL mid_after_valid got=%b exp=%b", s_vld, s_exp_vld); end
            if (s_rsp) begin
                total++; if (!s_exp_ok || s_data !== FILL) begin bad++; $display("FAIL mid_after_data got=%h exp=%h", s_data, FILL); end
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_no_clear();
        logic saw_we;
        saw_we = 1'b0;
        rst2_b = 1'b1;
        @(negedge clk);
        saw_we = saw_we | nc_we;
        total++; if (nc_busy !== 1'b1 || nc_req_ready !== 1'b0) begin bad++; $display("FAIL nc_cycle1 got busy=%b rdy=%b exp 1 0", nc_busy, nc_req_ready); end
        @(posedge clk);
        #1;
        @(negedge clk);
        saw_we = saw_we | nc_we;
        total++; if (nc_busy !== 1'b0 || nc_req_ready !== 1'b1) begin bad++; $display("FAIL nc_cycle2 got busy=%b rdy=%b exp 0 1", nc_busy, nc_req_ready); end
        total++; if (saw_we !== 1'b0) begin bad++; $display("FAIL nc_no_write got=%b exp=0", saw_we); end
    endtask

    initial begin
        rst_b = 1'b0; rst2_b = 1'b0; model_run = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0; rsp_ready = 1'b0;
        nc_req_valid = 1'b0; nc_req_write = 1'b0; nc_req_addr = '0; nc_req_data = '0;
        nc_rsp_ready = 1'b1; nc_ram_dout = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        test_reset();
        test_sweep();
        test_streaming();
        test_backpressure();
        test_rd_then_wr();
        test_random();
        test_reset_mid();
        test_no_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
